// File: rtl/core_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  // Opcodes
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ALU operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Mux select codes
  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;
  localparam logic [1:0] A_PC       = 2'b00;
  localparam logic [1:0] A_OLDPC    = 2'b01;
  localparam logic [1:0] A_RS1      = 2'b10;
  localparam logic [1:0] B_RS2      = 2'b00;
  localparam logic [1:0] B_IMM      = 2'b01;
  localparam logic [1:0] B_FOUR     = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // Immediate format selects
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_SW:   imm_sel = IMM_S;
      OP_BEQ:  imm_sel = IMM_B;
      OP_JAL:  imm_sel = IMM_J;
      default: imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// Latency: n/a (wiring only).
// Backpressure: mem_ready from the unified memory stalls FETCH/MEMREAD/MEMWRITE.
// master = controller (consumes instruction fields/status, drives controls);
// slave  = datapath (the opposite directions).
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic [1:0] imm_src;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] result_src;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       illegal_instr;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output imm_src, adr_src, alu_src_a, alu_src_b, alu_control, result_src,
           pc_write, ir_write, reg_write, mem_write, illegal_instr
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  imm_src, adr_src, alu_src_a, alu_src_b, alu_control, result_src,
           pc_write, ir_write, reg_write, mem_write, illegal_instr
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps ALU operation class plus instruction fields to an ALU control code.
// Latency: combinational.
// Backpressure: none.
// Ports: alu_op, funct3, op5 (instr[5]), funct7b5 in; alu_control out.
module alu_decoder
  import core_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only means sub for R-type; addi reuses that bit as immediate.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core (lw, sw, R/I ALU, beq, jal).
// Latency: lw 5, sw 4, R/I 4, beq 3, jal 4, illegal 2 cycles at zero wait states.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; ignored elsewhere.
// Ports: clock, reset (async active-low); ctrl (master) carries instruction
// fields, zero, mem_ready in and all mux selects, ALU control and strobes out.
module multicycle_controller
  import core_ctrl_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  multicycle_controller_if.master ctrl
);

  state_t     state, state_nxt;
  logic [1:0] alu_op;
  logic       pc_update, branch;
  logic       ir_wr, reg_wr, mem_wr, illegal;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    ctrl.adr_src    = ADR_PC;
    ctrl.alu_src_a  = A_PC;
    ctrl.alu_src_b  = B_RS2;
    ctrl.result_src = RES_ALUOUT;
    alu_op          = ALUOP_ADD;
    pc_update       = 1'b0;
    branch          = 1'b0;
    ir_wr           = 1'b0;
    reg_wr          = 1'b0;
    mem_wr          = 1'b0;
    illegal         = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_b  = B_FOUR;
        ctrl.result_src = RES_ALURES;
        if (ctrl.mem_ready) begin
          ir_wr     = 1'b1;
          pc_update = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target from the old PC while decoding.
        ctrl.alu_src_a = A_OLDPC;
        ctrl.alu_src_b = B_IMM;
        case (ctrl.op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXECR;
          OP_ITYPE:     state_nxt = S_EXECI;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          default: begin
            illegal   = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_IMM;
        state_nxt      = (ctrl.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = ADR_ALUOUT;
        ctrl.result_src = RES_ALUOUT;
        if (ctrl.mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_RDATA;
        reg_wr          = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.adr_src = ADR_ALUOUT;
        mem_wr       = 1'b1;
        if (ctrl.mem_ready) state_nxt = S_FETCH;
      end
      S_EXECR: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_RS2;
        alu_op         = ALUOP_FUNCT;
        state_nxt      = S_ALUWB;
      end
      S_EXECI: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_IMM;
        alu_op         = ALUOP_FUNCT;
        state_nxt      = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        reg_wr          = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = A_RS1;
        ctrl.alu_src_b  = B_RS2;
        ctrl.result_src = RES_ALUOUT;
        alu_op          = ALUOP_SUB;
        branch          = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_JAL: begin
        // Return address (old PC + 4) goes to rd via ALUWB; target from DECODE.
        ctrl.alu_src_a  = A_OLDPC;
        ctrl.alu_src_b  = B_FOUR;
        ctrl.result_src = RES_ALUOUT;
        pc_update       = 1'b1;
        state_nxt       = S_ALUWB;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // FETCH strobes depend on mem_ready, so they are masked while reset is low
  // to keep the register file, PC and memory untouched during reset.
  assign ctrl.pc_write      = reset & (pc_update | (branch & ctrl.zero));
  assign ctrl.ir_write      = reset & ir_wr;
  assign ctrl.reg_write     = reset & reg_wr;
  assign ctrl.mem_write     = reset & mem_wr;
  assign ctrl.illegal_instr = reset & illegal;
  assign ctrl.imm_src       = imm_sel(ctrl.op);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (ctrl.funct3),
    .op5         (ctrl.op[5]),
    .funct7b5    (ctrl.funct7b5),
    .alu_control (ctrl.alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cases plus randomized instructions
// checked cycle by cycle against a per-instruction phase model.
module tb_multicycle_controller;

  logic clock = 1'b0;
  logic reset;
  multicycle_controller_if bus();

  multicycle_controller dut (.clock(clock), .reset(reset), .ctrl(bus));

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // Bench-local phase numbering.
  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5,
                 P_ER = 6, P_EI = 7, P_AW = 8, P_B = 9, P_J = 10;
  string pname [11] = '{"fetch","decode","memadr","memread","memwb","memwrite",
                        "execr","execi","aluwb","beq","jal"};

  int mw_seen;

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit known_op(input logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                     7'b1100011, 7'b1101111};
  endfunction

  function automatic int ref_imm(input logic [6:0] o);
    if (o == 7'b0100011) return 1;
    if (o == 7'b1100011) return 2;
    if (o == 7'b1101111) return 3;
    return 0;
  endfunction

  // ALU function for R/I instructions straight from the funct3 table.
  function automatic int ref_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == 7'b0110011 && f7) ? 1 : 0;
      3'b010:  return 5;
      3'b110:  return 3;
      3'b111:  return 2;
      default: return 0;
    endcase
  endfunction

  // Expected outputs of one cycle in phase p; -1 marks a field left unspecified.
  task automatic check_cycle(input int p, input logic mr);
    int e_pcw, e_irw, e_rw, e_mw, e_ill, e_adr, e_a, e_b, e_alu, e_res;
    string s;
    s = pname[p];
    e_pcw = 0; e_irw = 0; e_rw = 0; e_mw = 0; e_ill = 0;
    e_adr = -1; e_a = -1; e_b = -1; e_alu = -1; e_res = -1;
    case (p)
      P_F:   begin e_adr = 0; e_a = 0; e_b = 2; e_alu = 0; e_res = 2;
                   e_pcw = int'(mr); e_irw = int'(mr); end
      P_D:   begin e_a = 1; e_b = 1; e_alu = 0; e_ill = known_op(bus.op) ? 0 : 1; end
      P_MA:  begin e_a = 2; e_b = 1; e_alu = 0; end
      P_MR:  begin e_adr = 1; e_res = 0; end
      P_MWB: begin e_res = 1; e_rw = 1; end
      P_MW:  begin e_adr = 1; e_mw = 1; end
      P_ER:  begin e_a = 2; e_b = 0; e_alu = ref_alu(bus.op, bus.funct3, bus.funct7b5); end
      P_EI:  begin e_a = 2; e_b = 1; e_alu = ref_alu(bus.op, bus.funct3, bus.funct7b5); end
      P_AW:  begin e_res = 0; e_rw = 1; end
      P_B:   begin e_a = 2; e_b = 0; e_alu = 1; e_res = 0; e_pcw = int'(bus.zero); end
      P_J:   begin e_a = 1; e_b = 2; e_alu = 0; e_res = 0; e_pcw = 1; end
      default: ;
    endcase
    if (bus.mem_write) mw_seen++;
    chk({s, ".pc_write"}, int'(bus.pc_write), e_pcw);
    chk({s, ".ir_write"}, int'(bus.ir_write), e_irw);
    chk({s, ".reg_write"}, int'(bus.reg_write), e_rw);
    chk({s, ".mem_write"}, int'(bus.mem_write), e_mw);
    chk({s, ".illegal"}, int'(bus.illegal_instr), e_ill);
    chk({s, ".imm_src"}, int'(bus.imm_src), ref_imm(bus.op));
    if (e_adr >= 0) chk({s, ".adr_src"}, int'(bus.adr_src), e_adr);
    if (e_a >= 0)   chk({s, ".alu_src_a"}, int'(bus.alu_src_a), e_a);
    if (e_b >= 0)   chk({s, ".alu_src_b"}, int'(bus.alu_src_b), e_b);
    if (e_alu >= 0) chk({s, ".alu_control"}, int'(bus.alu_control), e_alu);
    if (e_res >= 0) chk({s, ".result_src"}, int'(bus.result_src), e_res);
  endtask

  // mode 0: memory always ready; 1: random mem_ready everywhere (waits capped);
  // 2: mem_ready low for the first 3 MEMWRITE cycles.
  // Entered and left at posedge+1 with the DUT in FETCH.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int mode);
    int ph[$];
    int stall;
    logic mr;
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
    ph = '{P_F, P_D};
    case (o)
      7'b0000011: ph = {ph, P_MA, P_MR, P_MWB};
      7'b0100011: ph = {ph, P_MA, P_MW};
      7'b0110011: ph = {ph, P_ER, P_AW};
      7'b0010011: ph = {ph, P_EI, P_AW};
      7'b1100011: ph = {ph, P_B};
      7'b1101111: ph = {ph, P_J, P_AW};
      default: ;
    endcase
    mw_seen = 0;
    foreach (ph[i]) begin
      stall = 0;
      forever begin
        case (mode)
          0:       mr = 1'b1;
          1:       mr = (stall >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
          default: mr = (ph[i] == P_MW && stall < 3) ? 1'b0 : 1'b1;
        endcase
        bus.mem_ready = mr;
        #2;
        check_cycle(ph[i], mr);
        @(posedge clock); #1;
        if (ph[i] inside {P_F, P_MR, P_MW} && !mr) stall++;
        else break;
      end
    end
  endtask

  initial begin
    logic [6:0] rop;
    logic [6:0] ops [6];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

    // Reset: strobes stay low even with memory ready; FETCH selects visible.
    reset = 1'b0;
    bus.op = 7'b0000011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
    bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #3;
    chk("rst.ir_write", int'(bus.ir_write), 0);
    chk("rst.pc_write", int'(bus.pc_write), 0);
    chk("rst.reg_write", int'(bus.reg_write), 0);
    chk("rst.mem_write", int'(bus.mem_write), 0);
    chk("rst.illegal", int'(bus.illegal_instr), 0);
    chk("rst.alu_src_b", int'(bus.alu_src_b), 2);
    chk("rst.result_src", int'(bus.result_src), 2);
    @(posedge clock); #2;
    chk("rst_edge.ir_write", int'(bus.ir_write), 0);
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;

    // Directed instructions.
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0);            // lw
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 2);            // sw, 3 waits
    chk("sw.mem_write_cycles", mw_seen, 4);
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0);            // sub
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0);            // addi
    run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 0);            // and
    run_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 0);            // slt
    run_instr(7'b0010011, 3'b110, 1'b0, 1'b0, 0);            // ori
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0);            // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0);            // beq not taken
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0);            // jal
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0);            // illegal
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1);            // lw, random waits

    // Reset in the middle of a stalled MEMWRITE.
    bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clock);               // FETCH, DECODE, MEMADR
    #1;
    bus.mem_ready = 1'b0;
    #2;
    chk("mid.mem_write_before", int'(bus.mem_write), 1);
    bus.mem_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("mid.mem_write", int'(bus.mem_write), 0);
    chk("mid.ir_write", int'(bus.ir_write), 0);
    chk("mid.pc_write", int'(bus.pc_write), 0);
    chk("mid.alu_src_b", int'(bus.alu_src_b), 2);
    chk("mid.adr_src", int'(bus.adr_src), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("rel.ir_write", int'(bus.ir_write), 1);
    chk("rel.pc_write", int'(bus.pc_write), 1);
    @(posedge clock); #1;
    bus.op = 7'b0000000;                       // leave DECODE through the illegal path
    #1;
    chk("rel.decode_a", int'(bus.alu_src_a), 1);
    chk("rel.decode_ir_write", int'(bus.ir_write), 0);
    chk("rel.decode_illegal", int'(bus.illegal_instr), 1);
    @(posedge clock); #1;

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do rop = 7'($urandom_range(0, 127)); while (known_op(rop));
      end else begin
        rop = ops[$urandom_range(0, 5)];
      end
      run_instr(rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
